memory_bank_arbiter: RTL
========================

Name: memory_bank_arbiter

Overview:
- Sequences and shares a bank of DEPTH 32-bit memory words (register-based, one enable per word) between NUM_REQ requesters.
- After reset, the block runs a zero-fill pass over every word.
- It then grants one access per cycle using round-robin arbitration.
- Sits between client logic and the word array. It drives the per-word enables and the shared write data, and returns registered read data.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DEPTH, 8, number of 32-bit words in the bank (2..64; need not be a power of two).
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_we  input  NUM_REQ  per-requester write (1) / read (0).
- req_addr  input  NUM_REQ*AW  per-requester word address; slice i = [i*AW +: AW].
- req_wdata  input  NUM_REQ*32  per-requester write data; slice i = [i*32 +: 32].
- req_ready  output  NUM_REQ  one-hot grant; the transfer for requester i occurs when req_valid[i] & req_ready[i].
- rsp_valid  output  NUM_REQ  one-hot; pulses for one cycle with read data for requester i.
- rsp_rdata  output  32  read data, valid only while rsp_valid is nonzero.
- word_en  output  DEPTH  per-word write enable to the word array.
- word_d  output  32  shared write data to all words.
- word_q  input  DEPTH*32  concatenated word outputs; word k = [k*32 +: 32].
- init_done  output  1  high once the zero-fill pass has completed.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, word_en=0, word_d=0, init_done=0, rr_ptr=0, init counter=0. State goes to INIT.
- The FSM has two states, INIT and SERVE.
- INIT:
  - Each cycle: word_en = one-hot(init_cnt), word_d = 0, init_cnt increments.
  - req_ready is held at 0.
  - After the cycle that writes word DEPTH-1, go to SERVE and set init_done=1 (registered, so it is first visible in the cycle after the last fill write).
  - Fill duration: exactly DEPTH cycles after reset deasserts.
- SERVE arbitration:
  - Combinational round-robin over req_valid, starting the search at rr_ptr.
  - req_ready is one-hot at the winner, or all zero if no request is valid.
  - req_ready may be observed in the same cycle as req_valid (zero-cycle grant).
  - On a grant to requester i, rr_ptr becomes (i+1) mod NUM_REQ at the next edge. With no grant, rr_ptr holds.
- SERVE write:
  - In the grant cycle, word_en = one-hot(addr) combinationally and word_d = wdata.
  - The word array captures the data at that edge.
- SERVE read:
  - In the grant cycle, word_q[addr] is registered into rsp_rdata, and rsp_valid[i] is set for the following cycle.
  - Read latency is 1 cycle.
  - A new grant can issue in the same cycle as a pending response (full throughput, one access per cycle).
- Same-address write then read on consecutive cycles: the read returns the new data.
- A requester whose req_valid is deasserted is skipped without losing its turn order.
- A single active requester is granted every cycle.
- Reset mid-operation:
  - Any pending rsp_valid is dropped.
  - rr_ptr is cleared and INIT restarts from word 0.
  - word_en is forced to 0 during the reset cycle.
- Address >= DEPTH:
  - Without the optional feature, the access is granted but ignored.
  - An ignored write drives word_en = 0.
  - An ignored read returns rsp_rdata = 0 with rsp_valid still pulsed.

Optional Feature:
- Macro: MEM_ARB_ADDR_ERR_EN.
- When defined:
  - Adds output port addr_err (1 bit, reset 0).
  - On any granted access with address >= DEPTH, addr_err pulses high for one cycle, aligned with the cycle where rsp_valid would appear.
  - For reads, rsp_valid still pulses with rsp_rdata = 0.
- When undefined: the port is absent, and out-of-range accesses are ignored silently as described in Behaviour.

Test Plan:
- Init fill: pre-load words with 0xFFFFFFFF, then assert reset for 1 cycle. Required: word_en walks 0x01, 0x02 … 0x80 over 8 cycles, all 8 words read back 0, and init_done rises at cycle 9.
- Single write/read: requester 0 writes 0xDEADBEEF to address 3, then reads address 3. Required: word_en=0x08 in the write cycle, and rsp_valid=0b01 with rsp_rdata=0xDEADBEEF one cycle after the read grant.
- Contention: both requesters hold req_valid for 6 cycles. Required: req_ready alternates 01, 10, 01, 10, 01, 10, with no cycle granting both.
- Back-to-back: requester 1 writes 0x12345678 to address 5, and requester 0 reads address 5 in the next cycle. Required: the read returns 0x12345678.
- Reset mid-traffic: assert reset in the cycle after a read grant. Required: no rsp_valid pulse, INIT restarts at word 0, and req_ready stays 0 for 8 cycles.
- Out-of-range with MEM_ARB_ADDR_ERR_EN: DEPTH=6, write to address 7. Required: word_en=0 and addr_err pulses once; a read of address 6 returns rsp_rdata=0 with addr_err=1.

Source files
------------

// File: rtl/memory_bank_arbiter.sv
// memory_bank_arbiter
// Shares a register-based bank of DEPTH 32-bit words between NUM_REQ
// requesters. After reset the bank is zero-filled one word per cycle (INIT),
// then one access per cycle is granted in round-robin order (SERVE).
// Writes drive the per-word enables and shared write data combinationally in
// the grant cycle; reads return registered data one cycle after the grant.
// Optional feature: define MEM_ARB_ADDR_ERR_EN to add the addr_err output,
// which flags granted accesses whose address is beyond the bank.
module memory_bank_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [DEPTH-1:0]      word_en,
  output logic [31:0]           word_d,
  input  logic [DEPTH*32-1:0]   word_q,
  output logic                  init_done
`ifdef MEM_ARB_ADDR_ERR_EN
  ,output logic                 addr_err
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        init_cnt_q, init_cnt_d;
  logic                 init_done_q, init_done_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
`ifdef MEM_ARB_ADDR_ERR_EN
  logic                 addr_err_q, addr_err_d;
`endif

  // Winner of the current arbitration round and its request fields
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_we;
  logic [AW-1:0]        gnt_addr;
  logic [31:0]          gnt_wdata;
  logic                 gnt_in_range;

  // Address decodes for the winner and for the fill counter
  logic [DEPTH-1:0]     addr_hit;
  logic [DEPTH-1:0]     init_hit;
  logic [31:0]          rd_word;

  // Round-robin search over req_valid starting at rr_ptr_q; first valid wins
  always_comb begin : arb
    int            idx;
    logic [PW-1:0] cand;
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path through the block leaves a value held and no latch is built.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PW'(idx);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Select the winning requester's command and check its address range
  always_comb begin
    gnt_we       = req_we[gnt_idx];
    gnt_addr     = req_addr[int'(gnt_idx)*AW +: AW];
    gnt_wdata    = req_wdata[int'(gnt_idx)*32 +: 32];
    gnt_in_range = ({1'b0, gnt_addr} < (AW+1)'(DEPTH));
  end

  // One-hot decodes and read mux; out-of-range addresses match no word
  always_comb begin
    addr_hit = '0;
    init_hit = '0;
    rd_word  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      addr_hit[k] = (int'(gnt_addr) == k);
      init_hit[k] = (int'(init_cnt_q) == k);
      if (int'(gnt_addr) == k) rd_word = word_q[k*32 +: 32];
    end
  end

  // Next-state and output logic for the INIT/SERVE sequencer
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    word_en     = '0;
    word_d      = '0;
`ifdef MEM_ARB_ADDR_ERR_EN
    addr_err_d  = 1'b0;
`endif

    case (state_q)
      ST_INIT: begin
        // Zero one word per cycle; requesters are held off until done
        word_en = init_hit;
        if (int'(init_cnt_q) == DEPTH - 1) begin
          state_d     = ST_SERVE;
          init_done_d = 1'b1;
          init_cnt_d  = '0;
        end else begin
          init_cnt_d  = init_cnt_q + 1'b1;
        end
      end

      ST_SERVE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          if (gnt_we) begin
            // Out-of-range writes are granted but touch no word
            word_en = gnt_in_range ? addr_hit : '0;
            word_d  = gnt_wdata;
          end else begin
            rsp_valid_d[gnt_idx] = 1'b1;
            rsp_rdata_d          = gnt_in_range ? rd_word : 32'h0;
          end
`ifdef MEM_ARB_ADDR_ERR_EN
          addr_err_d = ~gnt_in_range;
`endif
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Nothing reaches the requesters or the word array while reset is high
    if (reset) begin
      req_ready = '0;
      word_en   = '0;
      word_d    = '0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef MEM_ARB_ADDR_ERR_EN
      addr_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_ARB_ADDR_ERR_EN
      addr_err_q  <= addr_err_d;
`endif
    end
  end

  // A response pending when reset arrives is dropped immediately
  assign rsp_valid = rsp_valid_q & {NUM_REQ{~reset}};
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
`ifdef MEM_ARB_ADDR_ERR_EN
  assign addr_err  = addr_err_q;
`endif

endmodule
